// File: rtl/or_accum_sched.sv
// rtl/or_accum_sched.sv - round-robin scheduler merging requester words into one OR accumulator
// Optional strict priority for requester 0: define OR_ACCUM_SCHED_PRIO0_EN.
module or_accum_sched #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic                         CLK,
  input  logic                         RESETN,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ*WIDTH-1:0]        req_data,
  output logic [NREQ-1:0]              req_ready,
  input  logic                         flush,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(BURST+1)-1:0]   out_count,
  input  logic                         out_ready
);

  localparam int CW = $clog2(BURST+1);
  localparam int PW = $clog2(NREQ);

  typedef enum logic {ACCUM = 1'b0, DRAIN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            out_valid_q, out_valid_d;

  logic [NREQ-1:0] grant;
  logic [PW-1:0]   gidx;
  logic            found;
  int              idx;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] merged;
  logic            go_drain;

  // Grant search starts at ptr; no grants while held in reset or draining.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    if (RESETN && state_q == ACCUM) begin
`ifdef OR_ACCUM_SCHED_PRIO0_EN
      if (req_valid[0]) begin
        found    = 1'b1;
        grant[0] = 1'b1;
      end
`endif
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(ptr_q) + k) % NREQ;
        if (!found && req_valid[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          gidx       = PW'(idx);
        end
      end
    end
  end

  assign req_ready = grant;
  assign word      = req_data[gidx*WIDTH +: WIDTH];
  assign merged    = acc_q | word;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    go_drain    = 1'b0;
    case (state_q)
      ACCUM: begin
        if (found) begin
          acc_d = merged;
          cnt_d = cnt_q + CW'(1);
`ifdef OR_ACCUM_SCHED_PRIO0_EN
          if (gidx != '0) ptr_d = PW'((int'(gidx) + 1) % NREQ);
`else
          ptr_d = PW'((int'(gidx) + 1) % NREQ);
`endif
        end
        go_drain = (found && (int'(cnt_q) + 1 == BURST)) ||
                   (flush && (cnt_q != '0 || found));
        if (go_drain) begin
          state_d     = DRAIN;
          out_valid_d = 1'b1;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = ACCUM;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = acc_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_or_accum_sched.sv
// tb/tb_or_accum_sched.sv - scoreboard bench for or_accum_sched with directed vectors
module tb_or_accum_sched;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        flush;
  logic        out_valid;
  logic [3:0]  out_data;
  logic [2:0]  out_count;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] data;
    logic [2:0] count;
  } exp_t;
  exp_t sb[$];

  or_accum_sched #(.WIDTH(4), .NREQ(4), .BURST(4)) dut (
    .CLK(CLK), .RESETN(RESETN),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .flush(flush),
    .out_valid(out_valid), .out_data(out_data), .out_count(out_count),
    .out_ready(out_ready)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  task automatic push(input logic [3:0] d, input logic [2:0] c);
    exp_t e;
    e.data  = d;
    e.count = c;
    sb.push_back(e);
  endtask

  // Monitor: every accepted drain is matched against the oldest expectation.
  always @(negedge CLK) begin
    if (RESETN === 1'b1 && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_drain", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("drain_data", 32'(out_data), 32'(e.data));
        chk("drain_count", 32'(out_count), 32'(e.count));
      end
    end
  end

  initial begin
    logic [3:0] single_words [4];
    single_words[0] = 4'h1; single_words[1] = 4'h2;
    single_words[2] = 4'h4; single_words[3] = 4'h8;

    RESETN = 1'b0; req_valid = 4'hF; req_data = 16'h8421; flush = 1'b0; out_ready = 1'b0;
    cyc(); cyc();
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    chk("reset_out_count", 32'(out_count), 32'd0);

    // Fairness: two bursts with all requesters valid, data_i = 1<<i.
    RESETN = 1'b1; out_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
`ifdef OR_ACCUM_SCHED_PRIO0_EN
      push(4'h1, 3'd4);
`else
      push(4'hF, 3'd4);
`endif
      for (int g = 0; g < 4; g++) begin
        mid();
`ifdef OR_ACCUM_SCHED_PRIO0_EN
        chk("fair_grant", 32'(req_ready), 32'h1);
`else
        chk("fair_grant", 32'(req_ready), 32'(1 << g));
`endif
        cyc();
      end
      mid();
      chk("fair_drain_ready", 32'(req_ready), 32'd0);
      chk("fair_drain_valid", 32'(out_valid), 32'd1);
      cyc();
    end
    req_valid = 4'h0; out_ready = 1'b0;

    // Single requester 2 feeding 1,2,4,8, then backpressure.
    push(4'hF, 3'd4);
    req_valid = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      req_data = {4'h0, single_words[k], 8'h00};
      mid();
      chk("single_grant", 32'(req_ready), 32'h4);
      cyc();
    end
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      mid();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'hF);
      chk("bp_count", 32'(out_count), 32'd4);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    req_valid = 4'h0; out_ready = 1'b0;
    mid();
    chk("bp_after_valid", 32'(out_valid), 32'd0);
    chk("bp_after_acc", 32'(out_data), 32'd0);
    chk("bp_after_count", 32'(out_count), 32'd0);
    cyc();

    // Flush with the second transfer folds that word in.
    req_valid = 4'b0010; req_data = 16'h0030;
    mid();
    chk("flush_grant1", 32'(req_ready), 32'h2);
    cyc();
    req_data = 16'h0040; flush = 1'b1;
    push(4'h7, 3'd2);
    mid();
    chk("flush_grant2", 32'(req_ready), 32'h2);
    cyc();
    flush = 1'b0; req_valid = 4'h0;
    mid();
    chk("flush_valid", 32'(out_valid), 32'd1);
    chk("flush_data", 32'(out_data), 32'h7);
    chk("flush_count", 32'(out_count), 32'd2);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;

    // Flush on an empty accumulator is ignored.
    flush = 1'b1;
    cyc(); cyc();
    mid();
    chk("empty_flush_valid", 32'(out_valid), 32'd0);
    cyc();
    flush = 1'b0;

    // Reset while draining discards the pending mask and rewinds ptr.
    req_valid = 4'b0010; req_data = 16'h00A0; flush = 1'b1;
    cyc();
    req_valid = 4'h0; flush = 1'b0;
    mid();
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    chk("pre_reset_data", 32'(out_data), 32'hA);
    chk("pre_reset_count", 32'(out_count), 32'd1);
    RESETN = 1'b0;
    cyc();
    RESETN = 1'b1; req_valid = 4'hF;
    mid();
    chk("post_reset_valid", 32'(out_valid), 32'd0);
    chk("post_reset_count", 32'(out_count), 32'd0);
    chk("post_reset_data", 32'(out_data), 32'd0);
    chk("post_reset_ptr_grant", 32'(req_ready), 32'h1);
    cyc();
    req_valid = 4'h0;
    cyc();

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
